interval_meter: RTL and testbench

//   Counterpart to the load-value countdown timer: it recovers an interval from a pulse train.

---
 rtl/interval_meter_pkg.sv | 14 +
 rtl/sat_counter.sv | 35 +++
 rtl/interval_meter.sv | 120 ++++++++++++
 tb/tb_interval_meter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/interval_meter_pkg.sv
// Shared timer definitions: measurement FSM state encoding and the default counter width.
// No logic; imported by interval_meter and sat_counter.
// No flow control of its own.
package interval_meter_pkg;

  localparam int DEFAULT_WIDTH = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STALE   = 2'd2
  } meter_state_e;

endpackage : interval_meter_pkg

// File: rtl/sat_counter.sv
// Interval counter: clear to 0, load to 1, +1 per enabled cycle, sticks at all-ones.
// One-cycle registered update; sat is decoded from the stored count.
// No backpressure; clr beats load, load beats inc.
module sat_counter
  import interval_meter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

  assign sat = (count == COUNT_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= COUNT_ONE;
    end else if (inc && !sat) begin
      count <= count + COUNT_ONE;
    end
  end

endmodule : sat_counter

// File: rtl/interval_meter.sv
// Measures clock cycles between successive tick_in pulses; reports interval with a valid strobe.
// Latency: interval/valid registered, valid one cycle after the closing tick is sampled.
// No backpressure: each strobe lasts one cycle and must be taken when offered.
module interval_meter
  import interval_meter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             meas_en,
  input  logic             tick_in,
  output logic [WIDTH-1:0] interval,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  meter_state_e     state_q;
  meter_state_e     state_d;
  logic             cnt_clr;
  logic             cnt_load;
  logic             cnt_inc;
  logic [WIDTH-1:0] cnt;
  logic             cnt_sat;
  logic             cap;
  logic             cap_sat;
  logic             ovf_d;

  sat_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .count (cnt),
    .sat   (cnt_sat)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    cap      = 1'b0;
    cap_sat  = 1'b0;
    ovf_d    = overflow;
    // Disabling wins over everything, including a coincident tick.
    if (!meas_en) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tick_in) begin
            state_d  = ST_MEASURE;
            cnt_load = 1'b1;
          end else begin
            cnt_clr = 1'b1;
          end
        end
        ST_MEASURE: begin
          // A tick both closes the running interval and opens the next one.
          if (tick_in) begin
            cnt_load = 1'b1;
            cap      = 1'b1;
            ovf_d    = 1'b0;
          end else if (cnt_sat) begin
            state_d = ST_STALE;
            ovf_d   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ST_STALE: begin
          if (tick_in) begin
            state_d  = ST_MEASURE;
            cnt_load = 1'b1;
            cap      = 1'b1;
            cap_sat  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      interval <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid    <= cap;
      overflow <= ovf_d;
      busy     <= (state_d != ST_IDLE);
      if (cap) begin
        interval <= cap_sat ? COUNT_MAX : cnt;
      end
    end
  end

endmodule : interval_meter

// File: tb/tb_interval_meter.sv
// Directed bench for interval_meter: expected intervals go to a scoreboard when the closing
// tick is driven and are matched (value, overflow, arrival edge) when valid appears.
module tb_interval_meter;

  localparam int W = 9;

  logic         clock = 1'b0;
  logic         reset;
  logic         meas_en;
  logic         tick_in;
  logic [W-1:0] interval;
  logic         valid;
  logic         overflow;
  logic         busy;

  int vectors     = 0;
  int miscompares = 0;
  int edge_cnt    = 0;

  typedef struct {
    int           exp_edge;
    logic [W-1:0] ival;
    logic         ovf;
  } exp_t;

  exp_t sb[$];

  interval_meter #(
    .WIDTH (W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .meas_en  (meas_en),
    .tick_in  (tick_in),
    .interval (interval),
    .valid    (valid),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge and are sampled by the following rising edge.
  task automatic drive(input logic en, input logic tk);
    @(negedge clock);
    meas_en = en;
    tick_in = tk;
  endtask

  task automatic run(input int n);
    repeat (n) drive(1'b1, 1'b0);
  endtask

  task automatic tick_exp(input logic [W-1:0] iv, input logic ov);
    exp_t e;
    drive(1'b1, 1'b1);
    e.exp_edge = edge_cnt + 1;
    e.ival     = iv;
    e.ovf      = ov;
    sb.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag, input logic [W-1:0] iv);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_interval"}, interval, iv);
  endtask

  always @(negedge clock) begin
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("valid_without_tick", valid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("valid_edge", edge_cnt, e.exp_edge);
        check("interval", interval, e.ival);
        check("overflow_at_valid", overflow, e.ovf);
      end
    end
  end

  initial begin
    reset   = 1'b0;
    meas_en = 1'b0;
    tick_in = 1'b0;

    // Reset held with the inputs active.
    repeat (2) begin
      @(negedge clock);
      meas_en = 1'b1;
      tick_in = ~tick_in;
      check_idle_outputs("reset", '0);
    end
    @(negedge clock);
    meas_en = 1'b0;
    tick_in = 1'b0;
    reset   = 1'b1;

    // Single interval of 64.
    drive(1'b1, 1'b1);
    run(63);
    tick_exp(9'd64, 1'b0);
    drive(1'b1, 1'b0);
    check("measure_busy", busy, 1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    check_idle_outputs("disabled_hold64", 9'd64);

    // Periodic ticks every 3 cycles.
    drive(1'b1, 1'b1);
    repeat (4) begin
      run(2);
      tick_exp(9'd3, 1'b0);
    end
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);

    // Back-to-back ticks.
    drive(1'b1, 1'b1);
    repeat (4) tick_exp(9'd1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    check_idle_outputs("disabled_hold1", 9'd1);

    // Saturation, stale closing tick, then recovery.
    drive(1'b1, 1'b1);
    run(511);
    check("pre_sat_overflow", overflow, 0);
    check("pre_sat_busy", busy, 1);
    drive(1'b1, 1'b0);
    check("sat_overflow", overflow, 1);
    run(88);
    check("stale_overflow", overflow, 1);
    check("stale_busy", busy, 1);
    tick_exp(9'd511, 1'b1);
    run(19);
    tick_exp(9'd20, 1'b0);
    drive(1'b1, 1'b0);
    check("recovered_overflow", overflow, 0);

    // Disable with a coincident tick, then re-arm.
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    run(29);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    check_idle_outputs("drop_en", 9'd20);
    drive(1'b1, 1'b1);
    run(7);
    tick_exp(9'd8, 1'b0);
    run(3);
    check("pre_reset_interval", interval, 8);

    // Asynchronous reset between edges while measuring.
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("async_reset", '0);
    drive(1'b1, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 1'b1);
    run(4);
    tick_exp(9'd5, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);

    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_interval_meter
